// File: rtl/pkg_en.sv
// Token-channel types shared by element links, plus round-robin arbiter constants.
// The forward-token i field exists only when EXTEND is defined.
package pkg_en;

    localparam int unsigned TK_DATA_W      = 16;
    localparam int unsigned TK_ARB_MAX_REQ = 16;
`ifdef EXTEND
    localparam int unsigned TK_ID_W        = 4;
`endif

    typedef struct packed {
        logic                 v;
        logic                 a;
        logic                 r;
`ifdef EXTEND
        logic [TK_ID_W-1:0]   i;
`endif
        logic [TK_DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping around.
// Produces a one-hot winner and a found flag.
module rr_picker
    import pkg_en::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               found
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IW'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tk_arbiter.sv
// Message-level round-robin arbiter sharing one token channel among NUM_REQ requesters.
// Define TK_ARB_WDOG_EN to build the idle watchdog that force-releases a silent grant.
module tk_arbiter
    import pkg_en::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  FTk_t [NUM_REQ-1:0] I_FTk,
    output BTk_t [NUM_REQ-1:0] O_BTk,
    output FTk_t               O_FTk,
    input  BTk_t               I_BTk,
    output logic [NUM_REQ-1:0] O_Grant,
    output logic               O_Err
);

    localparam int unsigned IW = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > TK_ARB_MAX_REQ) begin : g_bad_num_req
        $error("tk_arbiter: NUM_REQ out of range");
    end

    arb_state_t         state_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      gidx_q;
    logic [NUM_REQ-1:0] grant_q;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] winner;
    logic               found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      next_ptr;
    FTk_t               gtk;
    logic               rel;
    logic               wd_fire;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req[k] = I_FTk[k].v & I_FTk[k].a;
        end
    end

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .winner(winner),
        .found (found)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (winner[k]) win_idx = IW'(k);
        end
    end

    assign gtk      = I_FTk[gidx_q];
    // Only a transferred (not nacked) release word ends the message.
    assign rel      = (state_q == BUSY) && gtk.v && !I_BTk.n && gtk.r;
    assign next_ptr = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= BUSY;
                        gidx_q  <= win_idx;
                        grant_q <= winner;
                    end
                end
                BUSY: begin
                    if (rel || wd_fire) begin
                        state_q <= IDLE;
                        ptr_q   <= next_ptr;
                        grant_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_Grant = grant_q;

    // Losers and idle requesters are held off by echoing their valid as nack.
    always_comb begin
        O_FTk = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            O_BTk[k]   = '0;
            O_BTk[k].n = I_FTk[k].v;
        end
        if (state_q == BUSY) begin
            O_FTk         = gtk;
            O_BTk[gidx_q] = I_BTk;
        end
    end

`ifdef TK_ARB_WDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    assign wd_fire = (state_q == BUSY) && (wd_cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= wd_fire && !rel;
            if (state_q != BUSY || rel || wd_fire || gtk.v) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + CW'(1);
            end
        end
    end

    assign O_Err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wd_fire        = 1'b0;
    assign O_Err          = 1'b0;
`endif

endmodule

// File: tb/tb_tk_arbiter.sv
// Bench for tk_arbiter: directed scenarios plus randomized traffic against a message-level
// reference model. Define TK_ARB_WDOG_EN to exercise the watchdog (TIMEOUT = 8).
module tb_tk_arbiter;
    import pkg_en::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;
    localparam int IW      = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    FTk_t [NUM_REQ-1:0] ftk;
    BTk_t               btk;
    BTk_t [NUM_REQ-1:0] o_btk;
    FTk_t               o_ftk;
    logic [NUM_REQ-1:0] o_grant;
    logic               o_err;

    int n_checks = 0;
    int n_fail   = 0;

    tk_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .I_FTk  (ftk),
        .O_BTk  (o_btk),
        .O_FTk  (o_ftk),
        .I_BTk  (btk),
        .O_Grant(o_grant),
        .O_Err  (o_err)
    );

    always #5 clock = ~clock;

    // Reference model: owner of the channel (-1 = none), round-robin start, silent-cycle count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_idle  = 0;
    int mk      = 0;
    bit m_err   = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_idle  = 0;
            m_err   = 1'b0;
        end else if (m_owner < 0) begin
            m_err = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                mk = (m_ptr + i) % NUM_REQ;
                if (m_owner < 0 && ftk[IW'(mk)].v && ftk[IW'(mk)].a) begin
                    m_owner = mk;
                    m_idle  = 0;
                end
            end
        end else begin
            m_err = 1'b0;
            if (ftk[IW'(m_owner)].v && !btk.n && ftk[IW'(m_owner)].r) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
            end
`ifdef TK_ARB_WDOG_EN
            else if (m_idle == TIMEOUT) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_err   = 1'b1;
            end
`endif
            else begin
                m_idle = ftk[IW'(m_owner)].v ? 0 : m_idle + 1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        ftk   = '0;
        btk   = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    function automatic FTk_t word(bit a, bit r, logic [TK_DATA_W-1:0] d);
        FTk_t w = '0;
        w.v = 1'b1;
        w.a = a;
        w.r = r;
        w.d = d;
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        ftk   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ftk[k] = word(1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
            ftk[k].v = 1'($urandom_range(0, 1));
        end
        btk = 4'($urandom);
        step();
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== '0) begin
            n_fail++; $display("FAIL reset_grant: got %b want 0", o_grant);
        end
        n_checks++;
        if (o_ftk !== '0) begin
            n_fail++; $display("FAIL reset_ftk: got %h want 0", o_ftk);
        end
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", o_err);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            n_checks++;
            if (o_btk[k] !== {ftk[k].v, 3'b000}) begin
                n_fail++; $display("FAIL reset_btk%0d: got %b want %b", k, o_btk[k], {ftk[k].v, 3'b000});
            end
        end
        reset = 1'b0;
        ftk   = '0;
        btk   = '0;
        step();
    endtask

    task automatic test_single_message();
        logic [TK_DATA_W-1:0] data [3] = '{16'h11, 16'h22, 16'h33};
        ftk[1] = word(1'b1, 1'b0, data[0]);
        @(negedge clock);
        n_checks++;
        if (o_ftk !== '0) begin
            n_fail++; $display("FAIL single_acq_fwd: got %h want 0", o_ftk);
        end
        n_checks++;
        if (o_btk[1].n !== 1'b1) begin
            n_fail++; $display("FAIL single_acq_nack: got %b want 1", o_btk[1].n);
        end
        step();
        for (int w = 0; w < 3; w++) begin
            ftk[1] = word(w == 0, w == 2, data[w]);
            @(negedge clock);
            n_checks++;
            if (o_grant !== 4'b0010) begin
                n_fail++; $display("FAIL single_grant: got %b want 0010", o_grant);
            end
            n_checks++;
            if (o_ftk !== word(w == 0, w == 2, data[w]) || o_btk[1].n !== 1'b0) begin
                n_fail++; $display("FAIL single_word%0d: got %h n=%b want %h n=0", w, o_ftk,
                                   o_btk[1].n, word(w == 0, w == 2, data[w]));
            end
            step();
        end
        ftk = '0;
        @(negedge clock);
        n_checks++;
        if (o_grant !== '0 || o_ftk !== '0) begin
            n_fail++; $display("FAIL single_idle_after: got grant %b ftk %h want 0", o_grant, o_ftk);
        end
        step();
        // With the pointer now at 2, requester 2 must beat requester 0.
        ftk[0] = word(1'b1, 1'b1, 16'($urandom));
        ftk[2] = word(1'b1, 1'b1, 16'($urandom));
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0100) begin
            n_fail++; $display("FAIL single_ptr_after: got %b want 0100", o_grant);
        end
        step();
        ftk = '0;
        step();
    endtask

    task automatic test_contention();
        logic [TK_DATA_W-1:0] d0a, d0b, d2;
        d0a = 16'($urandom);
        d0b = 16'($urandom);
        d2  = 16'($urandom);
        pulse_reset();
        ftk[0] = word(1'b1, 1'b0, d0a);
        ftk[2] = word(1'b1, 1'b1, d2);
        @(negedge clock);
        n_checks++;
        if (o_btk[0].n !== 1'b1 || o_btk[2].n !== 1'b1 || o_grant !== '0) begin
            n_fail++; $display("FAIL cont_arb_cycle: got n0=%b n2=%b grant %b want 1 1 0000",
                               o_btk[0].n, o_btk[2].n, o_grant);
        end
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0001 || o_ftk !== word(1'b1, 1'b0, d0a) || o_btk[2].n !== 1'b1) begin
            n_fail++; $display("FAIL cont_req0_first: got grant %b ftk %h n2=%b want 0001 %h 1",
                               o_grant, o_ftk, o_btk[2].n, word(1'b1, 1'b0, d0a));
        end
        step();
        ftk[0] = word(1'b0, 1'b1, d0b);
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0001 || o_ftk !== word(1'b0, 1'b1, d0b)) begin
            n_fail++; $display("FAIL cont_req0_release: got grant %b ftk %h want 0001 %h",
                               o_grant, o_ftk, word(1'b0, 1'b1, d0b));
        end
        step();
        ftk[0] = '0;
        @(negedge clock);
        n_checks++;
        if (o_grant !== '0 || o_ftk !== '0 || o_btk[2].n !== 1'b1) begin
            n_fail++; $display("FAIL cont_bubble: got grant %b ftk %h n2=%b want 0000 0 1",
                               o_grant, o_ftk, o_btk[2].n);
        end
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0100 || o_ftk !== word(1'b1, 1'b1, d2) || o_btk[2].n !== 1'b0) begin
            n_fail++; $display("FAIL cont_req2_served: got grant %b ftk %h n2=%b want 0100 %h 0",
                               o_grant, o_ftk, o_btk[2].n, word(1'b1, 1'b1, d2));
        end
        step();
        ftk = '0;
        step();
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] exp_g [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        FTk_t exp_f;
        pulse_reset();
        for (int k = 0; k < NUM_REQ; k++) ftk[k] = word(1'b1, 1'b1, 16'($urandom));
        for (int c = 0; c < 10; c++) begin
            exp_f = '0;
            for (int k = 0; k < NUM_REQ; k++) if (exp_g[c][k]) exp_f = ftk[k];
            @(negedge clock);
            n_checks++;
            if (o_grant !== exp_g[c] || o_ftk !== exp_f) begin
                n_fail++; $display("FAIL fair_cycle%0d: got grant %b ftk %h want %b %h", c, o_grant,
                                   o_ftk, exp_g[c], exp_f);
            end
            step();
        end
        ftk = '0;
        step();
        step();
    endtask

    task automatic test_downstream_nack();
        logic [TK_DATA_W-1:0] d [3];
        bit   nk [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        FTk_t seen [$];
        int   wi = 0;
        for (int j = 0; j < 3; j++) d[j] = 16'($urandom);
        pulse_reset();
        ftk[3] = word(1'b1, 1'b0, d[0]);
        step();
        for (int c = 0; c < 6; c++) begin
            ftk[3] = word(wi == 0, wi == 2, d[wi]);
            btk    = '0;
            btk.n  = nk[c];
            @(negedge clock);
            n_checks++;
            if (o_grant !== 4'b1000 || o_btk[3].n !== nk[c]) begin
                n_fail++; $display("FAIL nack_cycle%0d: got grant %b n3=%b want 1000 %b", c, o_grant,
                                   o_btk[3].n, nk[c]);
            end
            if (o_ftk.v && !btk.n) seen.push_back(o_ftk);
            if (!nk[c]) wi++;
            step();
        end
        ftk = '0;
        btk = '0;
        @(negedge clock);
        n_checks++;
        if (o_grant !== '0) begin
            n_fail++; $display("FAIL nack_released: got %b want 0000", o_grant);
        end
        n_checks++;
        if (seen.size() != 3) begin
            n_fail++; $display("FAIL nack_word_count: got %0d want 3", seen.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (seen[j] !== word(j == 0, j == 2, d[j])) begin
                    n_fail++; $display("FAIL nack_word%0d: got %h want %h", j, seen[j],
                                       word(j == 0, j == 2, d[j]));
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_message();
        logic [TK_DATA_W-1:0] d1, d2, d3;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        d3 = 16'($urandom);
        pulse_reset();
        ftk[1] = word(1'b1, 1'b0, 16'($urandom));
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0010) begin
            n_fail++; $display("FAIL rstmid_grant: got %b want 0010", o_grant);
        end
        step();
        ftk[1] = word(1'b0, 1'b0, d1);
        @(negedge clock);
        n_checks++;
        if (o_ftk !== word(1'b0, 1'b0, d1)) begin
            n_fail++; $display("FAIL rstmid_word1: got %h want %h", o_ftk, word(1'b0, 1'b0, d1));
        end
        step();
        ftk[1] = word(1'b0, 1'b0, d2);
        reset  = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (o_ftk !== '0 || o_grant !== '0 || o_btk[1].n !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_abandoned%0d: got ftk %h grant %b n1=%b want 0 0000 1",
                                   c, o_ftk, o_grant, o_btk[1].n);
            end
            step();
        end
        ftk[1] = word(1'b1, 1'b1, d3);
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0010 || o_ftk !== word(1'b1, 1'b1, d3)) begin
            n_fail++; $display("FAIL rstmid_reacquire: got grant %b ftk %h want 0010 %h", o_grant,
                               o_ftk, word(1'b1, 1'b1, d3));
        end
        step();
        ftk = '0;
        step();
    endtask

`ifdef TK_ARB_WDOG_EN
    task automatic test_watchdog();
        pulse_reset();
        ftk[0] = word(1'b1, 1'b0, 16'($urandom));
        ftk[1] = word(1'b1, 1'b0, 16'($urandom));
        step();
        @(negedge clock);
        n_checks++;
        if (o_grant !== 4'b0001) begin
            n_fail++; $display("FAIL wdog_grant: got %b want 0001", o_grant);
        end
        step();
        ftk[0] = '0;
        for (int c = 0; c < TIMEOUT + 1; c++) begin
            @(negedge clock);
            n_checks++;
            if (o_grant !== 4'b0001 || o_err !== 1'b0) begin
                n_fail++; $display("FAIL wdog_hold%0d: got grant %b err %b want 0001 0", c, o_grant,
                                   o_err);
            end
            step();
        end
        @(negedge clock);
        n_checks++;
        if (o_err !== 1'b1 || o_grant !== '0) begin
            n_fail++; $display("FAIL wdog_fire: got err %b grant %b want 1 0000", o_err, o_grant);
        end
        step();
        @(negedge clock);
        n_checks++;
        if (o_err !== 1'b0 || o_grant !== 4'b0010) begin
            n_fail++; $display("FAIL wdog_next: got err %b grant %b want 0 0010", o_err, o_grant);
        end
        step();
        ftk = '0;
        step();
    endtask
`else
    task automatic test_grant_hold();
        pulse_reset();
        ftk[0] = word(1'b1, 1'b0, 16'($urandom));
        ftk[1] = word(1'b1, 1'b0, 16'($urandom));
        step();
        step();
        ftk[0] = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n_checks++;
            if (o_grant !== 4'b0001 || o_err !== 1'b0) begin
                n_fail++; $display("FAIL hold%0d: got grant %b err %b want 0001 0", c, o_grant, o_err);
            end
            step();
        end
        ftk = '0;
        step();
    endtask
`endif

    task automatic test_random();
        logic [NUM_REQ-1:0] eg;
        FTk_t               ef;
        BTk_t               eb;
        int                 vprob;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            vprob = ((c / 40) % 2 == 0) ? 2 : 10;
            for (int k = 0; k < NUM_REQ; k++) begin
                ftk[k]   = word($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom));
                ftk[k].v = ($urandom_range(0, vprob - 1) == 0);
            end
            btk   = 4'($urandom);
            btk.n = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            eg = '0;
            ef = '0;
            if (m_owner >= 0) begin
                eg[IW'(m_owner)] = 1'b1;
                ef = ftk[IW'(m_owner)];
            end
            n_checks++;
            if (o_grant !== eg) begin
                n_fail++; $display("FAIL rand_grant@%0d: got %b want %b", c, o_grant, eg);
            end
            n_checks++;
            if (o_ftk !== ef) begin
                n_fail++; $display("FAIL rand_ftk@%0d: got %h want %h", c, o_ftk, ef);
            end
            n_checks++;
            if (o_err !== m_err) begin
                n_fail++; $display("FAIL rand_err@%0d: got %b want %b", c, o_err, m_err);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                eb = (k == m_owner) ? btk : BTk_t'({ftk[k].v, 3'b000});
                n_checks++;
                if (o_btk[k] !== eb) begin
                    n_fail++; $display("FAIL rand_btk%0d@%0d: got %b want %b", k, c, o_btk[k], eb);
                end
            end
            step();
        end
        ftk = '0;
        btk = '0;
        step();
    endtask

    initial begin
        ftk = '0;
        btk = '0;
        test_reset();
        test_single_message();
        test_contention();
        test_fairness();
        test_downstream_nack();
        test_reset_mid_message();
`ifdef TK_ARB_WDOG_EN
        test_watchdog();
`else
        test_grant_hold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got no finish want finish within 1ms");
        $fatal(1, "simulation time limit");
    end

endmodule
